// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, FSM encoding and the forwarding-select helper for the
// pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] WB_SRC_LOAD = 2'b01;

  typedef enum logic {
    RUN,
    WAIT
  } mem_state_e;

  // Memory stage wins over writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs_e,
                                         input logic [4:0] rd_m,
                                         input logic       wr_m,
                                         input logic [4:0] rd_w,
                                         input logic       wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs_e)) return FWD_M;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs_e)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: register addresses and
// memory handshake in, stall/flush/forward controls and counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);

  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic             rd_write_e;
  logic [1:0]       rd_write_src_e;
  logic             pc_write_e;
  logic [4:0]       rd_m;
  logic             rd_write_m;
  logic [4:0]       rd_w;
  logic             rd_write_w;
  logic             dmem_req_m;
  logic             dmem_ready;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic [1:0]       forwarding_rs1_e;
  logic [1:0]       forwarding_rs2_e;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_write_e, rd_write_src_e, pc_write_e,
           rd_m, rd_write_m, rd_w, rd_write_w, dmem_req_m, dmem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           forwarding_rs1_e, forwarding_rs2_e, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_write_e, rd_write_src_e, pc_write_e,
           rd_m, rd_write_m, rd_w, rd_write_w, dmem_req_m, dmem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           forwarding_rs1_e, forwarding_rs2_e, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_mem_fsm.sv
// Data-memory wait sequencer: RUN/WAIT FSM with a watchdog that forces the
// stall to release after TIMEOUT waiting cycles.
module hazard_mem_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_dmem_req,
  input  logic i_dmem_ready,
  output logic o_mb,
  output logic o_to_hit,
  output logic o_mem_err
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  mem_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  logic            w_to_hit;

  assign w_to_hit  = (r_state == WAIT) && (TIMEOUT != 0) && (r_cnt == TimeoutVal);
  assign o_to_hit  = w_to_hit;
  assign o_mem_err = w_to_hit;
  // The expiry cycle itself is not stalled, so the pipeline moves on at once.
  assign o_mb      = i_dmem_req && !i_dmem_ready && !w_to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (i_dmem_req && !i_dmem_ready) begin
            r_state <= WAIT;
            r_cnt   <= CntW'(1);
          end
        end
        WAIT: begin
          if (i_dmem_ready || w_to_hit) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline: operand forwarding,
// load-use stall, redirect flush, memory wait stall and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave io_bus
);

  logic             w_mb;
  logic             w_unused_to_hit;
  logic             w_mem_err;
  logic             w_lu;
  logic             w_redirect;
  logic             w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic             w_flush_d, w_flush_e, w_flush_w;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  hazard_mem_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_dmem_req  (io_bus.dmem_req_m),
    .i_dmem_ready(io_bus.dmem_ready),
    .o_mb        (w_mb),
    .o_to_hit    (w_unused_to_hit),
    .o_mem_err   (w_mem_err)
  );

  // Checks rs2 even for instructions that ignore it; a spare bubble is harmless.
  assign w_lu = io_bus.rd_write_e && (io_bus.rd_write_src_e == WB_SRC_LOAD) &&
                (io_bus.rd_e != 5'd0) &&
                ((io_bus.rd_e == io_bus.rs1_d) || (io_bus.rd_e == io_bus.rs2_d));

  always_comb begin
    w_stall_f  = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_e  = 1'b0;
    w_stall_m  = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    w_flush_w  = 1'b0;
    w_redirect = 1'b0;
    if (!rst_n) begin
      w_redirect = 1'b0;
    end else if (w_mb) begin
      // Holding execute keeps pc_write_e alive until the wait ends.
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (io_bus.pc_write_e) begin
      w_flush_d  = 1'b1;
      w_flush_e  = 1'b1;
      w_redirect = 1'b1;
    end else if (w_lu) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign io_bus.stall_f   = w_stall_f;
  assign io_bus.stall_d   = w_stall_d;
  assign io_bus.stall_e   = w_stall_e;
  assign io_bus.stall_m   = w_stall_m;
  assign io_bus.flush_d   = w_flush_d;
  assign io_bus.flush_e   = w_flush_e;
  assign io_bus.flush_w   = w_flush_w;
  assign io_bus.mem_err   = w_mem_err;
  assign io_bus.stall_cnt = r_stall_cnt;
  assign io_bus.flush_cnt = r_flush_cnt;

  assign io_bus.forwarding_rs1_e = !rst_n ? FWD_RF :
      fwd_sel(io_bus.rs1_e, io_bus.rd_m, io_bus.rd_write_m, io_bus.rd_w, io_bus.rd_write_w);
  assign io_bus.forwarding_rs2_e = !rst_n ? FWD_RF :
      fwd_sel(io_bus.rs2_e, io_bus.rd_m, io_bus.rd_write_m, io_bus.rd_w, io_bus.rd_write_w);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT = 4: inputs change on the
// falling edge, combinational outputs are checked 1 ns later.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  localparam logic [6:0] CtrlNone = 7'b0000000;
  localparam logic [6:0] CtrlLu   = 7'b1100010;
  localparam logic [6:0] CtrlRed  = 7'b0000110;
  localparam logic [6:0] CtrlMb   = 7'b1111001;

  hazard_ctrl_if #(.CNT_W(32)) bus ();

  hazard_ctrl #(
    .TIMEOUT(4),
    .CNT_W  (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
              bus.flush_d, bus.flush_e, bus.flush_w}, {25'd0, exp});
  endtask

  task automatic idle();
    bus.rs1_d = 5'd0; bus.rs2_d = 5'd0; bus.rs1_e = 5'd0; bus.rs2_e = 5'd0;
    bus.rd_e = 5'd0; bus.rd_write_e = 1'b0; bus.rd_write_src_e = 2'b00;
    bus.pc_write_e = 1'b0; bus.rd_m = 5'd0; bus.rd_write_m = 1'b0;
    bus.rd_w = 5'd0; bus.rd_write_w = 1'b0; bus.dmem_req_m = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  initial begin
    // Reset with every hazard source active: outputs must all be forced low.
    idle();
    bus.rd_m = 5'd5; bus.rd_write_m = 1'b1; bus.rs1_e = 5'd5;
    bus.rd_e = 5'd3; bus.rd_write_e = 1'b1; bus.rd_write_src_e = WB_SRC_LOAD; bus.rs1_d = 5'd3;
    bus.pc_write_e = 1'b1; bus.dmem_req_m = 1'b1;
    #1;
    chk_ctrl("reset_ctrl", CtrlNone);
    chk("reset_fwd1", 32'(bus.forwarding_rs1_e), 32'(FWD_RF));
    @(negedge clk);
    chk("reset_stall_cnt", bus.stall_cnt, 32'd0);
    chk("reset_flush_cnt", bus.flush_cnt, 32'd0);
    chk("reset_mem_err", 32'(bus.mem_err), 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk_ctrl("idle_ctrl", CtrlNone);

    // Forwarding priority and x0.
    @(negedge clk);
    bus.rd_m = 5'd5; bus.rd_write_m = 1'b1; bus.rd_w = 5'd5; bus.rd_write_w = 1'b1;
    bus.rs1_e = 5'd5; bus.rs2_e = 5'd7;
    #1;
    chk("fwd1_mem", 32'(bus.forwarding_rs1_e), 32'(FWD_M));
    chk("fwd2_none", 32'(bus.forwarding_rs2_e), 32'(FWD_RF));
    @(negedge clk);
    bus.rd_write_m = 1'b0;
    #1;
    chk("fwd1_wb", 32'(bus.forwarding_rs1_e), 32'(FWD_W));
    @(negedge clk);
    bus.rd_write_m = 1'b1; bus.rs1_e = 5'd0; bus.rd_m = 5'd0; bus.rd_w = 5'd0;
    #1;
    chk("fwd1_x0", 32'(bus.forwarding_rs1_e), 32'(FWD_RF));

    // Load-use: one bubble, then writeback forward to the consumer.
    @(negedge clk);
    idle();
    bus.rd_e = 5'd3; bus.rd_write_e = 1'b1; bus.rd_write_src_e = WB_SRC_LOAD;
    bus.rs1_d = 5'd1; bus.rs2_d = 5'd3;
    #1;
    chk_ctrl("lu_stall", CtrlLu);
    @(negedge clk);
    bus.rd_write_e = 1'b0; bus.rd_e = 5'd0; bus.rd_m = 5'd3; bus.rd_write_m = 1'b1;
    #1;
    chk_ctrl("lu_one_cycle", CtrlNone);
    chk("lu_stall_cnt", bus.stall_cnt, 32'd1);
    @(negedge clk);
    idle();
    bus.rd_w = 5'd3; bus.rd_write_w = 1'b1; bus.rs2_e = 5'd3;
    #1;
    chk("lu_fwd2_wb", 32'(bus.forwarding_rs2_e), 32'(FWD_W));

    // Redirect overrides a pending load-use.
    @(negedge clk);
    idle();
    bus.rd_e = 5'd4; bus.rd_write_e = 1'b1; bus.rd_write_src_e = WB_SRC_LOAD;
    bus.rs1_d = 5'd4; bus.pc_write_e = 1'b1;
    #1;
    chk_ctrl("redirect_over_lu", CtrlRed);
    @(negedge clk);
    idle();
    #1;
    chk("redirect_flush_cnt", bus.flush_cnt, 32'd1);
    chk("redirect_stall_cnt", bus.stall_cnt, 32'd1);

    // Three wait cycles; a redirect raised mid-wait is issued when ready arrives.
    @(negedge clk);
    bus.dmem_req_m = 1'b1;
    #1;
    chk_ctrl("mb_c1", CtrlMb);
    @(negedge clk);
    bus.pc_write_e = 1'b1;
    #1;
    chk_ctrl("mb_c2_deferred", CtrlMb);
    @(negedge clk);
    #1;
    chk_ctrl("mb_c3", CtrlMb);
    chk("mb_c3_flush_cnt", bus.flush_cnt, 32'd1);
    @(negedge clk);
    bus.dmem_ready = 1'b1;
    #1;
    chk_ctrl("mb_ready_redirect", CtrlRed);
    chk("mb_ready_mem_err", 32'(bus.mem_err), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("mb_stall_cnt", bus.stall_cnt, 32'd4);
    chk("mb_flush_cnt", bus.flush_cnt, 32'd2);

    // Watchdog: four stalled cycles, then the release cycle with mem_err.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.dmem_req_m = 1'b1;
      #1;
      chk_ctrl($sformatf("to_stall_%0d", i), CtrlMb);
      chk($sformatf("to_no_err_%0d", i), 32'(bus.mem_err), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("to_mem_err", 32'(bus.mem_err), 32'd1);
    chk_ctrl("to_release", CtrlNone);
    @(negedge clk);
    idle();
    #1;
    chk("to_err_pulse_end", 32'(bus.mem_err), 32'd0);
    chk("to_stall_cnt", bus.stall_cnt, 32'd8);
    @(negedge clk);
    bus.dmem_req_m = 1'b1;
    #1;
    chk_ctrl("to_back_in_run", CtrlMb);
    chk("to_back_no_err", 32'(bus.mem_err), 32'd0);

    // Asynchronous reset while waiting with a deferred redirect.
    @(negedge clk);
    bus.pc_write_e = 1'b1; bus.rd_m = 5'd6; bus.rd_write_m = 1'b1; bus.rs2_e = 5'd6;
    #1;
    chk_ctrl("rst_wait_pre", CtrlMb);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ctrl("rst_async_ctrl", CtrlNone);
    chk("rst_async_fwd2", 32'(bus.forwarding_rs2_e), 32'(FWD_RF));
    chk("rst_async_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_async_flush_cnt", bus.flush_cnt, 32'd0);
    chk("rst_async_mem_err", 32'(bus.mem_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_hold_err_%0d", i), 32'(bus.mem_err), 32'd0);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk_ctrl("rst_release_ctrl", CtrlNone);
    chk("rst_release_mem_err", 32'(bus.mem_err), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_release_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_release_flush_cnt", bus.flush_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core. It generates forwarding selects for the execute stage, the load-use stall, and the taken-branch/jump flush. It also sequences data-memory wait states through a small FSM with a timeout watchdog, and keeps stall/flush performance counters. It sits beside the pipeline and drives the `stall_*`, `flush_*` and `forwarding_rs*_e` inputs of every stage.

## Interface
- `TIMEOUT`, 16: maximum wait cycles for `dmem_ready`; 0 disables the watchdog.
- `CNT_W`, 32: width of the performance counters.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs1_d`, `rs2_d` in 5: decode-stage source registers.
- `rs1_e`, `rs2_e` in 5: execute-stage source registers.
- `rd_e` in 5, `rd_write_e` in 1, `rd_write_src_e` in 2: execute-stage destination, write enable and writeback source (2'b01 = load).
- `pc_write_e` in 1: taken branch/jump resolved in execute.
- `rd_m` in 5, `rd_write_m` in 1: memory-stage destination and write enable.
- `rd_w` in 5, `rd_write_w` in 1: writeback-stage destination and write enable.
- `dmem_req_m` in 1: memory stage is accessing data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold the stage registers.
- `flush_d`, `flush_e`, `flush_w` out 1: bubble into the stage registers.
- `forwarding_rs1_e`, `forwarding_rs2_e` out 2: operand select (00 = register file, 01 = writeback, 10 = memory stage).
- `mem_err` out 1: one-cycle pulse on watchdog expiry.
- `stall_cnt` out CNT_W: number of cycles with `stall_f` = 1.
- `flush_cnt` out CNT_W: number of redirect flushes.

## Operation
- **Forwarding (per operand X in {rs1, rs2}).**
  - Select 10 if `rd_write_m` && `rd_m` != 0 && `rd_m` == X_e.
  - Otherwise select 01 if `rd_write_w` && `rd_w` != 0 && `rd_w` == X_e.
  - Otherwise select 00.
  - Memory has priority over writeback. Register x0 is never forwarded.
- **Load-use.** `lu` = `rd_write_e` && `rd_write_src_e` == 2'b01 && `rd_e` != 0 && (`rd_e` == `rs1_d` || `rd_e` == `rs2_d`). Both sources are compared even when the instruction does not use rs2; this conservative check is accepted.
- **Memory busy.** `mb` = `dmem_req_m` && !`dmem_ready` && !`to_hit`, where `to_hit` means the watchdog expires this cycle.
- **Output priority**, highest first:
  - `mb`: `stall_f`, `stall_d`, `stall_e`, `stall_m` = 1 and `flush_w` = 1; all other flushes 0.
  - `pc_write_e`: `flush_d` = 1 and `flush_e` = 1, no stalls. A pending `lu` is dropped because the decode instruction is killed.
  - `lu`: `stall_f` = 1, `stall_d` = 1, `flush_e` = 1.
  - Otherwise all stall and flush outputs are 0.
- A redirect arriving during `mb` is deferred, not lost. `stall_e` holds `pc_write_e` asserted, and the flush is issued in the first cycle without `mb`.
- **Memory FSM**, with states RUN and WAIT.
  - RUN to WAIT on `dmem_req_m` && !`dmem_ready`; the wait counter loads 1.
  - WAIT to RUN on `dmem_ready` or `to_hit`. Otherwise stay in WAIT and increment the counter.
  - `to_hit` = (state == WAIT) && `TIMEOUT` != 0 && counter == `TIMEOUT`. On `to_hit`, `mem_err` pulses and the stall is released in the same cycle.
- **Counters.** `stall_cnt` increments on every cycle with `stall_f` = 1. `flush_cnt` increments on every cycle where the `pc_write_e` flush is issued. Both wrap modulo 2^CNT_W.

## Timing
- Stall, flush and forwarding outputs are combinational from the current inputs and FSM state, with zero-cycle latency. Stages sample them at the next `posedge clk`.
- A memory access that is ready in the same cycle as its request causes no stall. Each extra wait cycle adds exactly one stall cycle.
- The watchdog releases the stall after `TIMEOUT` stalled cycles. `mem_err` is high for exactly that release cycle.
- Load-use always costs exactly one bubble. On the next cycle the load is in memory and the consumer is still in decode. One cycle later the consumer reaches execute and takes the writeback forward (01).
- **Reset.** While `rst_n` = 0:
  - the FSM is in RUN and the wait counter is 0;
  - `stall_cnt`, `flush_cnt` and `mem_err` are 0;
  - all stall and flush outputs are forced to 0 and both forwarding selects are forced to 00.
- An asynchronous reset in the middle of a WAIT aborts the wait without raising `mem_err`.

## Structure
- Package `hazard_pkg` holds:
  - forwarding constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - WB_SRC_LOAD = 2'b01;
  - the FSM state encoding (RUN, WAIT).
- Sub-module `hazard_mem_fsm` holds the RUN/WAIT FSM and the watchdog counter. It outputs `mb`, `to_hit` and `mem_err`.
- Forwarding, priority resolution and the counters live in the top module.

## Test plan
- `rd_m` = 5 with `rd_write_m` = 1, `rd_w` = 5 with `rd_write_w` = 1, `rs1_e` = 5 -> `forwarding_rs1_e` = 10. Then drop `rd_write_m` -> 01. Then set `rs1_e` = 0 with `rd_m` = `rd_w` = 0 -> 00.
- Load in execute with `rd_e` = 3; `rs2_d` = 3 -> `stall_f` = 1, `stall_d` = 1, `flush_e` = 1 for exactly one cycle. The following cycle `forwarding_rs2_e` = 01.
- `pc_write_e` = 1 together with `lu` -> `flush_d` = 1, `flush_e` = 1, `stall_d` = 0, and `flush_cnt` increments by 1.
- `dmem_req_m` = 1 with `dmem_ready` low for 3 cycles -> all four stalls and `flush_w` high for 3 cycles and `stall_cnt` += 3. Ready in the 4th cycle -> stalls drop that cycle.
- `TIMEOUT` = 4 with `dmem_ready` never asserted -> stall for 4 cycles, `mem_err` pulses in the 5th cycle, stall released and FSM back in RUN.
- `rst_n` pulsed low during WAIT with `pc_write_e` pending -> all outputs 0 and counters 0 immediately, and no `mem_err`.
